interrupt_scheduler: RTL

Five-source, two-level interrupt scheduler for the 8051 core, sitting between the peripheral flags (external pins, timers, serial) and the CPU control unit. It applies IE/IP enable and priority rules and tracks nesting of in-service levels across RETI. It presents one registered request plus vector to the CPU and emits the hardware flag-clear pulses on acknowledge.

---
 rtl/int_sched_pkg.sv | 25 ++
 rtl/ext_int_latch.sv | 27 ++
 rtl/interrupt_scheduler.sv | 89 ++++++++
 3 files changed

// File: rtl/int_sched_pkg.sv
// int_sched_pkg: shared constants, source/state encodings and helpers for interrupt_scheduler.
package int_sched_pkg;
  typedef enum logic [2:0] {SRC_EX0, SRC_TF0, SRC_EX1, SRC_TF1, SRC_SER} src_e;
  typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_HOLD} state_e;
  localparam int NSRC = 5;
  localparam logic LVL_LOW = 1'b0;
  localparam logic LVL_HIGH = 1'b1;
  localparam logic [7:0] VEC_EX0 = 8'h03;
  localparam logic [7:0] VEC_TF0 = 8'h0B;
  localparam logic [7:0] VEC_EX1 = 8'h13;
  localparam logic [7:0] VEC_TF1 = 8'h1B;
  localparam logic [7:0] VEC_SER = 8'h23;
  function automatic logic [7:0] vec_of(src_e s);
    return s == SRC_EX0 ? VEC_EX0 : s == SRC_TF0 ? VEC_TF0 : s == SRC_EX1 ? VEC_EX1 :
           s == SRC_TF1 ? VEC_TF1 : VEC_SER;
  endfunction
  // Lowest set index wins, giving EX0 > TF0 > EX1 > TF1 > SER.
  function automatic src_e first_src(logic [NSRC-1:0] m);
    src_e r;
    r = SRC_SER;
    for (int i = NSRC - 1; i >= 0; i--)
      if (m[i]) r = src_e'(3'(i));
    return r;
  endfunction
endpackage

// File: rtl/ext_int_latch.sv
// ext_int_latch: IE flag for one external pin; edge capture only when INT_SCHED_EXT_EDGE_EN is defined.
module ext_int_latch (
  input  logic clock,
  input  logic reset,
  input  logic it,
  input  logic ext_n,
  input  logic clr,
  output logic flag
);
`ifdef INT_SCHED_EXT_EDGE_EN
  logic ext_n_q, edge_q;
  always_ff @(posedge clock) begin
    if (!reset) begin
      ext_n_q <= 1'b1;
      edge_q <= 1'b0;
    end else begin
      ext_n_q <= ext_n;
      edge_q <= (ext_n_q && !ext_n) ? 1'b1 : clr ? 1'b0 : edge_q;
    end
  end
  assign flag = it ? edge_q : ~ext_n;
`else
  logic unused;
  assign unused = &{1'b0, clock, reset, it, clr};
  assign flag = ~ext_n;
`endif
endmodule

// File: rtl/interrupt_scheduler.sv
// interrupt_scheduler: 8051 five-source two-level interrupt scheduler; INT_SCHED_EXT_EDGE_EN enables edge-triggered external pins.
module interrupt_scheduler
  import int_sched_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] ie,
  input  logic [4:0] ip,
  input  logic       it0,
  input  logic       it1,
  input  logic       ext0_n,
  input  logic       ext1_n,
  input  logic       tf0,
  input  logic       tf1,
  input  logic       ser_flag,
  input  logic       int_ack,
  input  logic       reti,
  output logic       int_req,
  output logic [7:0] int_vec,
  output logic       tf0_clr,
  output logic       tf1_clr,
  output logic       ie0_clr,
  output logic       ie1_clr,
  output logic [1:0] in_service
);
  logic ie0_flag, ie1_flag;
  ext_int_latch u_ext0 (.clock(clock), .reset(reset), .it(it0), .ext_n(ext0_n), .clr(ie0_clr), .flag(ie0_flag));
  ext_int_latch u_ext1 (.clock(clock), .reset(reset), .it(it1), .ext_n(ext1_n), .clr(ie1_clr), .flag(ie1_flag));
  state_e state;
  src_e src_q, cand_src;
  logic lvl_q, cand_lvl, cand_ok, reti_ok, ack_ok;
  logic [NSRC-1:0] flags, elig, hi, lo;
  logic [1:0] clr_mask, set_mask, ie_clr_d;
  assign flags = {ser_flag, tf1, ie1_flag, tf0, ie0_flag};
  assign elig = ie[7] ? flags & ie[4:0] : '0;
  assign hi = elig & ip;
  assign lo = elig & ~ip;
  assign cand_lvl = |hi;
  assign cand_src = first_src(cand_lvl ? hi : lo);
  assign cand_ok = |elig && (cand_lvl ? !in_service[1] : in_service == 2'b00);
  assign reti_ok = reti && |in_service;
  assign ack_ok = int_ack && state == ST_PEND;
  // RETI retires the most recent (highest) level; a same-cycle ack re-sets its own level afterwards.
  assign clr_mask = !reti_ok ? 2'b00 : in_service[1] ? 2'b10 : 2'b01;
  assign set_mask = !ack_ok ? 2'b00 : lvl_q ? 2'b10 : 2'b01;
`ifdef INT_SCHED_EXT_EDGE_EN
  assign ie_clr_d = {ack_ok && src_q == SRC_EX1 && it1, ack_ok && src_q == SRC_EX0 && it0};
`else
  assign ie_clr_d = 2'b00;
`endif
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= ST_IDLE;
      int_req <= 1'b0;
      int_vec <= 8'h00;
      src_q <= SRC_EX0;
      lvl_q <= LVL_LOW;
      in_service <= 2'b00;
      tf0_clr <= 1'b0;
      tf1_clr <= 1'b0;
      ie0_clr <= 1'b0;
      ie1_clr <= 1'b0;
    end else begin
      in_service <= (in_service & ~clr_mask) | set_mask;
      tf0_clr <= ack_ok && src_q == SRC_TF0;
      tf1_clr <= ack_ok && src_q == SRC_TF1;
      ie0_clr <= ie_clr_d[0];
      ie1_clr <= ie_clr_d[1];
      case (state)
        ST_IDLE:
          if (reti_ok) state <= ST_HOLD;
          else if (cand_ok) begin
            state <= ST_PEND;
            int_req <= 1'b1;
            int_vec <= vec_of(cand_src);
            src_q <= cand_src;
            lvl_q <= cand_lvl;
          end
        ST_PEND:
          if (ack_ok || !ie[7]) begin
            state <= ST_IDLE;
            int_req <= 1'b0;
          end
        ST_HOLD: state <= reti_ok ? ST_HOLD : ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
